fp32_err_monitor: RTL and testbench
===================================

Name: fp32_err_monitor

Overview:
- Sits directly downstream of the fp32 multipliers on the approximate-multiplier test path.
- Each cycle it consumes one result pair: the exact fp32 product with its valid flag, and the approximate product with its valid flag.
- Per pair, it measures the error distance in units-in-last-place (ULP) between the two results.
- Over a window of WIN accepted pairs it accumulates statistics, then presents one report through a valid/ready handshake.

Parameters:
- WIN, 1024: number of result pairs accepted per window; range 1 to 2^CNT_W-1.
- CNT_W, 16: width of the sample counters and event counters.
- SUM_W, 48: width of the saturating error-sum accumulator; minimum 8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse; opens a window; honoured only in IDLE
- busy  out  1  high in any state except IDLE
- in_valid  in  1  an input pair is presented
- in_ready  out  1  block accepts a pair; a pair transfers when in_valid and in_ready are both high
- exact_res  in  32  exact fp32 product
- exact_vld  in  1  exact multiplier's valid flag (low on overflow/underflow)
- approx_res  in  32  approximate fp32 product
- approx_vld  in  1  approximate multiplier's valid flag
- rpt_valid  out  1  report is available
- rpt_ready  in  1  downstream takes the report
- rpt_max_err  out  32  largest ULP error in the window
- rpt_sum_err  out  SUM_W  saturating sum of ULP errors
- rpt_mism_cnt  out  CNT_W  number of pairs with nonzero error
- rpt_flag_cnt  out  CNT_W  number of pairs whose valid flags differ
- rpt_sat  out  1  rpt_sum_err saturated during the window

Behaviour:
- Reset: all outputs 0, all statistics 0, FSM in IDLE. Reset mid-window discards all partial statistics.
- FSM states: IDLE, ACCUM, DRAIN, REPORT.
  - IDLE → ACCUM on start. Entering ACCUM clears all statistics and the accept counter.
  - ACCUM: in_ready = 1 while accept count < WIN. The WIN-th transfer moves the FSM to DRAIN in the next cycle, with in_ready = 0.
  - DRAIN: lasts exactly 2 cycles (pipeline depth), then → REPORT.
  - REPORT: rpt_valid = 1. All rpt_* outputs are registered and held stable until rpt_ready; on rpt_valid & rpt_ready → IDLE.
  - in_ready = 0 in every state other than ACCUM.
- start is ignored in any state other than IDLE, including the cycle in which the report is taken.
- Ordering map: ord(x) = x[31] ? -{0,x[30:0]} : {0,x[30:0]}, as a 33-bit signed value.
  - +0 and -0 both map to 0.
  - NaN/Inf bit patterns are mapped with no special handling.
- Error: err = |ord(approx_res) - ord(exact_res)|, 32-bit unsigned. The maximum value is 2^32-2, so no clipping is needed.
- Flag rule, applied per pair:
  - exact_vld ≠ approx_vld: increment flag_cnt only; the pair is excluded from max, sum and mism.
  - Flags equal (both 1 or both 0): update max, sum and mism from err.
- Latency: a pair transferred at cycle t has its effect on the statistics at t+2 (stage 1 registers ord values; stage 2 registers err and the flag compare).
- Saturation: sum_err saturates at 2^SUM_W-1 and sets rpt_sat sticky for the rest of the window.
- Counters never wrap, because WIN ≤ 2^CNT_W-1.

Optional Feature:
- Macro: FP32_ERR_HIST_EN.
- When defined:
  - Adds output rpt_hist, width 8*CNT_W: eight bins of CNT_W bits each, bin 0 in the LSBs.
  - Bin edges: 0 / 1 / 2-3 / 4-15 / 16-255 / 256-65535 / 65536 to 2^24-1 / ≥2^24.
  - Only flag-equal pairs are counted.
  - Bins are cleared on entering ACCUM and held in REPORT.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fp32_err_pkg holds:
  - the FSM state enum;
  - the pipeline depth constant (2);
  - the histogram bin-edge constants;
  - the ord() function.
- Sub-module fp32_err_calc: the 2-stage pipeline from (exact_res, approx_res, vld flags, transfer strobe) to (err, flag_diff, out strobe).
- FSM and accumulators stay in the top level.

Test Plan:
1. WIN=4; four identical pairs 0x3F800000 with both flags = 1 → rpt_max_err 0, sum 0, mism 0, flag 0, rpt_sat 0.
2. WIN=4; exact 0x3F800000, approx alternating 0x3F800001 and 0x3F7FFFFF → max 1, sum 4, mism 4.
3. Signed-zero and sign-crossing checks:
   - 0x00000000 vs 0x80000000 → err 0;
   - 0x00000001 vs 0x80000001 → err 2;
   - 0x7F7FFFFF vs 0xFF7FFFFF → err 0xFEFFFFFE (single-sample window).
4. WIN=4; one pair with exact_vld=1, approx_vld=0 and 0x40000000 vs 0x00000000, the other three pairs with err 3 → flag_cnt 1, sum 9, max 3, mism 3.
5. Backpressure and saturation:
   - Hold rpt_ready=0 for 10 cycles in REPORT → outputs stable, in_ready 0, start pulses ignored; raise rpt_ready → IDLE next cycle, busy 0.
   - With SUM_W=8, two errors of 200 → sum 255, rpt_sat 1.
6. Assert rst after 2 of 4 transfers → all outputs 0 and busy 0 immediately. A new window of four err-0 pairs then reports all-zero statistics.

Source files
------------

// File: rtl/fp32_err_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp32_err_pkg
// Brief    : Shared types, constants and helpers for the fp32 ULP error monitor.
// Revision : 1.0 - initial release
// ============================================================================
package fp32_err_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   localparam int unsigned c_PIPE_DEPTH = 2;

   // Lower edge of histogram bins 1..7; bin 0 holds err == 0.
   localparam logic [31:0] c_HIST_EDGE_1 = 32'd1;
   localparam logic [31:0] c_HIST_EDGE_2 = 32'd2;
   localparam logic [31:0] c_HIST_EDGE_3 = 32'd4;
   localparam logic [31:0] c_HIST_EDGE_4 = 32'd16;
   localparam logic [31:0] c_HIST_EDGE_5 = 32'd256;
   localparam logic [31:0] c_HIST_EDGE_6 = 32'd65536;
   localparam logic [31:0] c_HIST_EDGE_7 = 32'h0100_0000;

   // Monotonic map of fp32 bit patterns onto signed integers; +0 and -0 coincide.
   function automatic logic signed [32:0] ord(input logic [31:0] x);
      logic signed [32:0] mag;
      mag = $signed({1'b0, x[30:0]});
      return x[31] ? -mag : mag;
   endfunction

   function automatic logic [2:0] hist_bin(input logic [31:0] err);
      if (err < c_HIST_EDGE_1)      return 3'd0;
      else if (err < c_HIST_EDGE_2) return 3'd1;
      else if (err < c_HIST_EDGE_3) return 3'd2;
      else if (err < c_HIST_EDGE_4) return 3'd3;
      else if (err < c_HIST_EDGE_5) return 3'd4;
      else if (err < c_HIST_EDGE_6) return 3'd5;
      else if (err < c_HIST_EDGE_7) return 3'd6;
      else                          return 3'd7;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_err_calc.sv
`default_nettype none
// ============================================================================
// Module   : fp32_err_calc
// Brief    : Two-stage pipeline producing the ULP error and flag mismatch per pair.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_err_calc
   import fp32_err_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        xfer,
   input  logic [31:0] exact_res,
   input  logic        exact_vld,
   input  logic [31:0] approx_res,
   input  logic        approx_vld,
   output logic        out_stb,
   output logic [31:0] err,
   output logic        flag_diff
);

   logic signed [32:0] r_ord_exact;
   logic signed [32:0] r_ord_approx;
   logic               r_flag_s1;
   logic               r_stb_s1;
   logic [31:0]        w_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ord_exact  <= '0;
         r_ord_approx <= '0;
         r_flag_s1    <= 1'b0;
         r_stb_s1     <= 1'b0;
      end else begin
         r_stb_s1 <= xfer;
         if (xfer) begin
            r_ord_exact  <= ord(exact_res);
            r_ord_approx <= ord(approx_res);
            r_flag_s1    <= exact_vld ^ approx_vld;
         end
      end
   end

   // |diff| never exceeds 2^32-2, so the low 32 bits of the ordered difference suffice.
   assign w_err = (r_ord_approx >= r_ord_exact) ? 32'(r_ord_approx - r_ord_exact)
                                                : 32'(r_ord_exact - r_ord_approx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_stb   <= 1'b0;
         err       <= '0;
         flag_diff <= 1'b0;
      end else begin
         out_stb <= r_stb_s1;
         if (r_stb_s1) begin
            err       <= w_err;
            flag_diff <= r_flag_s1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp32_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fp32_err_monitor
// Brief    : Windowed ULP error statistics between exact and approximate fp32 products.
// Options  : FP32_ERR_HIST_EN adds the eight-bin rpt_hist error histogram output.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_err_monitor
   import fp32_err_pkg::*;
#(
   parameter int WIN   = 1024,
   parameter int CNT_W = 16,
   parameter int SUM_W = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        exact_res,
   input  logic               exact_vld,
   input  logic [31:0]        approx_res,
   input  logic               approx_vld,
   output logic               rpt_valid,
   input  logic               rpt_ready,
   output logic [31:0]        rpt_max_err,
   output logic [SUM_W-1:0]   rpt_sum_err,
   output logic [CNT_W-1:0]   rpt_mism_cnt,
   output logic [CNT_W-1:0]   rpt_flag_cnt,
   output logic               rpt_sat
`ifdef FP32_ERR_HIST_EN
   ,
   output logic [8*CNT_W-1:0] rpt_hist
`endif
);

   localparam int                 c_ADD_W   = ((SUM_W > 32) ? SUM_W : 32) + 1;
   localparam logic [CNT_W-1:0]   c_WIN     = CNT_W'(WIN);
   localparam logic [c_ADD_W-1:0] c_SUM_MAX = (c_ADD_W'(1) << SUM_W) - c_ADD_W'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_drain_cnt;
   logic [CNT_W-1:0]    r_acc_cnt;
   logic                w_xfer;
   logic                w_last;
   logic                w_enter_accum;
   logic                w_stb;
   logic [31:0]         w_err;
   logic                w_flag_diff;
   logic [c_ADD_W-1:0]  w_sum_wide;
   logic                w_sum_ovf;
   logic [31:0]         r_max;
   logic [SUM_W-1:0]    r_sum;
   logic [CNT_W-1:0]    r_mism;
   logic [CNT_W-1:0]    r_flag;
   logic                r_sat;

   assign w_xfer        = in_valid & in_ready;
   assign w_last        = w_xfer && (r_acc_cnt == c_WIN - CNT_W'(1));
   assign w_enter_accum = (r_state == ST_IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_ACCUM;
         ST_ACCUM:  if (w_last) w_state_nxt = ST_DRAIN;
         ST_DRAIN:  if (r_drain_cnt == 2'(c_PIPE_DEPTH - 1)) w_state_nxt = ST_REPORT;
         ST_REPORT: if (rpt_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != ST_IDLE);
      in_ready  = (r_state == ST_ACCUM) && (r_acc_cnt < c_WIN);
      rpt_valid = (r_state == ST_REPORT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drain_cnt <= 2'd0;
         r_acc_cnt   <= '0;
      end else begin
         r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
         if (w_enter_accum)  r_acc_cnt <= '0;
         else if (w_xfer)    r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
   end

   fp32_err_calc u_calc (
      .clk        (clk),
      .rst        (rst),
      .xfer       (w_xfer),
      .exact_res  (exact_res),
      .exact_vld  (exact_vld),
      .approx_res (approx_res),
      .approx_vld (approx_vld),
      .out_stb    (w_stb),
      .err        (w_err),
      .flag_diff  (w_flag_diff)
   );

   assign w_sum_wide = c_ADD_W'(r_sum) + c_ADD_W'(w_err);
   assign w_sum_ovf  = (w_sum_wide > c_SUM_MAX);

   // Pairs with disagreeing valid flags only feed the flag counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_max  <= '0;
         r_sum  <= '0;
         r_mism <= '0;
         r_flag <= '0;
         r_sat  <= 1'b0;
      end else if (w_enter_accum) begin
         r_max  <= '0;
         r_sum  <= '0;
         r_mism <= '0;
         r_flag <= '0;
         r_sat  <= 1'b0;
      end else if (w_stb) begin
         if (w_flag_diff) begin
            r_flag <= r_flag + CNT_W'(1);
         end else begin
            if (w_err > r_max) r_max <= w_err;
            r_sum <= w_sum_ovf ? {SUM_W{1'b1}} : SUM_W'(w_sum_wide);
            if (w_sum_ovf)     r_sat <= 1'b1;
            if (w_err != '0)   r_mism <= r_mism + CNT_W'(1);
         end
      end
   end

   assign rpt_max_err  = r_max;
   assign rpt_sum_err  = r_sum;
   assign rpt_mism_cnt = r_mism;
   assign rpt_flag_cnt = r_flag;
   assign rpt_sat      = r_sat;

`ifdef FP32_ERR_HIST_EN
   logic [CNT_W-1:0] r_hist [8];
   logic [2:0]       w_bin;

   assign w_bin = hist_bin(w_err);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) r_hist[i] <= '0;
      end else if (w_enter_accum) begin
         for (int i = 0; i < 8; i++) r_hist[i] <= '0;
      end else if (w_stb && !w_flag_diff) begin
         r_hist[w_bin] <= r_hist[w_bin] + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_hist_out
      assign rpt_hist[g*CNT_W +: CNT_W] = r_hist[g];
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp32_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_err_monitor
// Brief    : Self-checking bench; two monitors (SUM_W 48 and 8) share one stimulus bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_err_monitor;

   localparam int WIN      = 4;
   localparam int CNT_W    = 16;
   localparam int SUM_W_WD = 48;
   localparam int SUM_W_NR = 8;

   typedef struct {
      logic [31:0] e;
      logic [31:0] a;
      logic        ve;
      logic        va;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] exact_res = '0;
   logic        exact_vld = 1'b0;
   logic [31:0] approx_res = '0;
   logic        approx_vld = 1'b0;
   logic        rpt_ready = 1'b0;

   logic                busy_wd, in_ready_wd, rpt_valid_wd, sat_wd;
   logic [31:0]         max_wd;
   logic [SUM_W_WD-1:0] sum_wd;
   logic [CNT_W-1:0]    mism_wd, flag_wd;
   logic                busy_nr, in_ready_nr, rpt_valid_nr, sat_nr;
   logic [31:0]         max_nr;
   logic [SUM_W_NR-1:0] sum_nr;
   logic [CNT_W-1:0]    mism_nr, flag_nr;
`ifdef FP32_ERR_HIST_EN
   logic [8*CNT_W-1:0]  hist_wd, hist_nr;
`endif

   always #5 clk = ~clk;

   fp32_err_monitor #(.WIN(WIN), .CNT_W(CNT_W), .SUM_W(SUM_W_WD)) u_dut_wd (
      .clk(clk), .rst(rst), .start(start), .busy(busy_wd),
      .in_valid(in_valid), .in_ready(in_ready_wd),
      .exact_res(exact_res), .exact_vld(exact_vld),
      .approx_res(approx_res), .approx_vld(approx_vld),
      .rpt_valid(rpt_valid_wd), .rpt_ready(rpt_ready),
      .rpt_max_err(max_wd), .rpt_sum_err(sum_wd),
      .rpt_mism_cnt(mism_wd), .rpt_flag_cnt(flag_wd), .rpt_sat(sat_wd)
`ifdef FP32_ERR_HIST_EN
      , .rpt_hist(hist_wd)
`endif
   );

   fp32_err_monitor #(.WIN(WIN), .CNT_W(CNT_W), .SUM_W(SUM_W_NR)) u_dut_nr (
      .clk(clk), .rst(rst), .start(start), .busy(busy_nr),
      .in_valid(in_valid), .in_ready(in_ready_nr),
      .exact_res(exact_res), .exact_vld(exact_vld),
      .approx_res(approx_res), .approx_vld(approx_vld),
      .rpt_valid(rpt_valid_nr), .rpt_ready(rpt_ready),
      .rpt_max_err(max_nr), .rpt_sum_err(sum_nr),
      .rpt_mism_cnt(mism_nr), .rpt_flag_cnt(flag_nr), .rpt_sat(sat_nr)
`ifdef FP32_ERR_HIST_EN
      , .rpt_hist(hist_nr)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   pair_t           pairs [$];
   longint unsigned m_max, m_sum;
   int              m_mism, m_flag;
   int              m_hist [8];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: fp32 patterns as sign-magnitude integers, error as plain distance.
   function automatic longint ordv(input logic [31:0] x);
      longint mag;
      mag = 0;
      mag[30:0] = x[30:0];
      return x[31] ? -mag : mag;
   endfunction

   function automatic int bin_of(input longint unsigned e);
      if (e == 0)            return 0;
      if (e == 1)            return 1;
      if (e < 4)             return 2;
      if (e < 16)            return 3;
      if (e < 256)           return 4;
      if (e < 65536)         return 5;
      if (e < (64'd1 << 24)) return 6;
      return 7;
   endfunction

   task automatic model_window();
      longint d;
      m_max = 0; m_sum = 0; m_mism = 0; m_flag = 0;
      for (int b = 0; b < 8; b++) m_hist[b] = 0;
      foreach (pairs[i]) begin
         if (pairs[i].ve != pairs[i].va) begin
            m_flag++;
         end else begin
            d = ordv(pairs[i].a) - ordv(pairs[i].e);
            if (d < 0) d = -d;
            if (longint'(d) > longint'(m_max)) m_max = d;
            m_sum += d;
            if (d != 0) m_mism++;
            m_hist[bin_of(d)]++;
         end
      end
   endtask

   task automatic check_ctrl(input string tag, input logic b, input logic r, input logic v);
      check({tag, ".busy_wd"},      busy_wd,      b);
      check({tag, ".busy_nr"},      busy_nr,      b);
      check({tag, ".in_ready_wd"},  in_ready_wd,  r);
      check({tag, ".in_ready_nr"},  in_ready_nr,  r);
      check({tag, ".rpt_valid_wd"}, rpt_valid_wd, v);
      check({tag, ".rpt_valid_nr"}, rpt_valid_nr, v);
   endtask

   task automatic check_report(input string tag);
      longint unsigned lim_wd, lim_nr;
      lim_wd = (64'd1 << SUM_W_WD) - 1;
      lim_nr = (64'd1 << SUM_W_NR) - 1;
      check({tag, ".max_wd"},  max_wd,  m_max);
      check({tag, ".max_nr"},  max_nr,  m_max);
      check({tag, ".sum_wd"},  sum_wd,  (m_sum > lim_wd) ? lim_wd : m_sum);
      check({tag, ".sum_nr"},  sum_nr,  (m_sum > lim_nr) ? lim_nr : m_sum);
      check({tag, ".sat_wd"},  sat_wd,  m_sum > lim_wd);
      check({tag, ".sat_nr"},  sat_nr,  m_sum > lim_nr);
      check({tag, ".mism_wd"}, mism_wd, m_mism);
      check({tag, ".mism_nr"}, mism_nr, m_mism);
      check({tag, ".flag_wd"}, flag_wd, m_flag);
      check({tag, ".flag_nr"}, flag_nr, m_flag);
`ifdef FP32_ERR_HIST_EN
      for (int b = 0; b < 8; b++) begin
         check($sformatf("%s.hist%0d_wd", tag, b), hist_wd[b*CNT_W +: CNT_W], m_hist[b]);
         check($sformatf("%s.hist%0d_nr", tag, b), hist_nr[b*CNT_W +: CNT_W], m_hist[b]);
      end
`endif
   endtask

   task automatic drive_pair(input pair_t p);
      exact_res  = p.e;
      approx_res = p.a;
      exact_vld  = p.ve;
      approx_vld = p.va;
   endtask

   task automatic add_pair(input logic [31:0] e, input logic [31:0] a, input logic ve, input logic va);
      pair_t p;
      p.e = e; p.a = a; p.ve = ve; p.va = va;
      pairs.push_back(p);
   endtask

   // One full window: start, WIN transfers with random gaps, drain, report hold, take.
   task automatic run_window(input string tag, input int hold);
      model_window();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      foreach (pairs[i]) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         drive_pair(pairs[i]);
         in_valid = 1'b1;
         check_ctrl($sformatf("%s.accum%0d", tag, i), 1'b1, 1'b1, 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_ctrl({tag, ".drain1"}, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_ctrl({tag, ".drain2"}, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_ctrl({tag, ".report"}, 1'b1, 1'b0, 1'b1);
      check_report(tag);
      for (int k = 0; k < hold; k++) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_ctrl($sformatf("%s.hold%0d", tag, k), 1'b1, 1'b0, 1'b1);
         check_report($sformatf("%s.hold%0d", tag, k));
      end
      start = 1'b1;
      rpt_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rpt_ready = 1'b0;
      check_ctrl({tag, ".taken"}, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_ctrl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check_ctrl(tag, 1'b0, 1'b0, 1'b0);
      pairs.delete();
      model_window();
      check_report(tag);
   endtask

   function automatic pair_t rand_pair();
      pair_t p;
      int    kind;
      kind = $urandom_range(0, 4);
      p.e  = $urandom;
      case (kind)
         0:       p.a = p.e;
         1:       p.a = p.e + 32'($urandom_range(0, 300));
         2:       p.a = $urandom;
         3:       begin p.e = {1'($urandom_range(0, 1)), 31'd0}; p.a = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 3))}; end
         default: p.a = p.e ^ 32'($urandom_range(0, 15));
      endcase
      p.ve = ($urandom_range(0, 7) != 0);
      p.va = ($urandom_range(0, 5) == 0) ? ~p.ve : p.ve;
      return p;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      pairs.delete();
      repeat (4) add_pair(32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b1);
      run_window("identical", 0);

      pairs.delete();
      for (int i = 0; i < 4; i++)
         add_pair(32'h3F80_0000, (i % 2 == 0) ? 32'h3F80_0001 : 32'h3F7F_FFFF, 1'b1, 1'b1);
      run_window("alternate", 0);

      pairs.delete();
      repeat (4) add_pair(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);
      run_window("signed_zero", 0);

      pairs.delete();
      repeat (4) add_pair(32'h0000_0001, 32'h8000_0001, 1'b1, 1'b1);
      run_window("sign_cross", 0);

      pairs.delete();
      add_pair(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1'b1, 1'b1);
      repeat (3) add_pair(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
      run_window("max_span", 0);

      pairs.delete();
      add_pair(32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0);
      add_pair(32'h3F80_0000, 32'h3F80_0003, 1'b1, 1'b1);
      add_pair(32'h3F80_0000, 32'h3F7F_FFFD, 1'b1, 1'b1);
      add_pair(32'hBF80_0000, 32'hBF80_0003, 1'b0, 1'b0);
      run_window("flag_rule", 10);

      pairs.delete();
      add_pair(32'h3F80_0000, 32'h3F80_00C8, 1'b1, 1'b1);
      add_pair(32'h3F80_0000, 32'h3F7F_FF38, 1'b1, 1'b1);
      repeat (2) add_pair(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
      run_window("saturate", 2);

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive_pair(rand_pair());
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;

      pairs.delete();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] v;
         v = $urandom;
         add_pair(v, v, 1'b1, 1'b1);
      end
      run_window("after_reset", 0);

      for (int w = 0; w < 25; w++) begin
         pairs.delete();
         repeat (WIN) pairs.push_back(rand_pair());
         run_window($sformatf("rand%0d", w), $urandom_range(0, 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
